// File: rtl/ft2232_fifo_master.sv
// ft2232_fifo_master: FPGA-side master for the FT2232H asynchronous 245-FIFO interface
module ft2232_fifo_master #(
  parameter int DATA      = 8,
  parameter int RD_CYC    = 3,
  parameter int WR_SETUP  = 1,
  parameter int WR_CYC    = 3,
  parameter int PRECHARGE = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [DATA-1:0] DBUS_I,
  output logic [DATA-1:0] DBUS_O,
  output logic            DBUS_OE,
  input  logic            RXF,
  input  logic            TXE,
  output logic            RD,
  output logic            WR,
  output logic            SIWU,
  output logic [DATA-1:0] rx_data,
  output logic            rx_valid,
  input  logic            rx_ready,
  input  logic [DATA-1:0] tx_data,
  input  logic            tx_valid,
  output logic            tx_ready,
  input  logic            flush
);
  typedef enum logic [2:0] {IDLE, RD_LOW, WR_SET, WR_LOW, WR_HOLD, SIWU_LOW, RECOVER} state_t;
  localparam logic [7:0] RD_LAST  = 8'(RD_CYC - 1);
  localparam logic [7:0] SET_LAST = 8'(WR_SETUP - 1);
  localparam logic [7:0] WR_LAST  = 8'(WR_CYC - 1);
  localparam logic [7:0] PRE_LAST = 8'(PRECHARGE - 1);
  state_t     state;
  logic [7:0] cnt;
  logic       rxf_m, rxf_s, txe_m, txe_s, fav_rd, flush_pend;
  logic       rd_ok, wr_ok, go_rd, go_wr, go_siwu;
  // IDLE arbitration: alternate when both sides are eligible, flush only when nothing else is
  always_comb begin
    rd_ok   = !rxf_s && (!rx_valid || rx_ready);
    wr_ok   = !txe_s && tx_valid;
    go_rd   = state == IDLE && rd_ok && (fav_rd || !wr_ok);
    go_wr   = state == IDLE && wr_ok && !go_rd;
    go_siwu = state == IDLE && !rd_ok && !wr_ok && flush_pend;
  end
  assign tx_ready = go_wr;
  // flag synchronisers, RX holding register and the strobe sequencer
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      rxf_m      <= 1'b1;
      rxf_s      <= 1'b1;
      txe_m      <= 1'b1;
      txe_s      <= 1'b1;
      fav_rd     <= 1'b1;
      flush_pend <= 1'b0;
      RD         <= 1'b1;
      WR         <= 1'b1;
      SIWU       <= 1'b1;
      DBUS_OE    <= 1'b0;
      DBUS_O     <= '0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
    end else begin
      rxf_m <= RXF;
      rxf_s <= rxf_m;
      txe_m <= TXE;
      txe_s <= txe_m;
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      if (go_siwu) flush_pend <= 1'b0;
      if (flush) flush_pend <= 1'b1;
      cnt <= cnt + 8'd1;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (go_rd || go_wr) fav_rd <= go_wr;
          if (go_rd) begin
            state <= RD_LOW;
            RD    <= 1'b0;
          end else if (go_wr) begin
            state   <= WR_SET;
            DBUS_O  <= tx_data;
            DBUS_OE <= 1'b1;
          end else if (go_siwu) begin
            state <= SIWU_LOW;
            SIWU  <= 1'b0;
          end
        end
        RD_LOW: if (cnt == RD_LAST) begin
          state    <= RECOVER;
          cnt      <= '0;
          RD       <= 1'b1;
          rx_data  <= DBUS_I;
          rx_valid <= 1'b1;
        end
        WR_SET: if (cnt == SET_LAST) begin
          state <= WR_LOW;
          cnt   <= '0;
          WR    <= 1'b0;
        end
        WR_LOW: if (cnt == WR_LAST) begin
          state <= WR_HOLD;
          cnt   <= '0;
          WR    <= 1'b1;
        end
        WR_HOLD: begin
          state   <= RECOVER;
          cnt     <= '0;
          DBUS_OE <= 1'b0;
        end
        SIWU_LOW: if (cnt == WR_LAST) begin
          state <= RECOVER;
          cnt   <= '0;
          SIWU  <= 1'b1;
        end
        RECOVER: if (cnt == PRE_LAST) begin
          state <= IDLE;
          cnt   <= '0;
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ft2232_fifo_master.sv
// tb_ft2232_fifo_master: vector table, directed corner cases and a randomized run against a device model
module tb_ft2232_fifo_master;
  localparam int PRE = 4;
  logic       clk = 1'b0;
  logic       rst, DBUS_OE, RXF, TXE, RD, WR, SIWU, rx_valid, rx_ready, tx_valid, tx_ready, flush;
  logic [7:0] DBUS_I, DBUS_O, rx_data, tx_data;
  int checks = 0, errors = 0;
  typedef struct {
    int n, rst, rxf, txe, txv, txd, rxr, fl, dbi;
    int rd, wr, siwu, oe, rxv, txr, rxd;
  } vec_t;
  vec_t vt[11];
  bit   dev_en = 1'b0, pend = 1'b0;
  int   rxf_cool = 0, txe_cool = 0, rx_got = 0, wr_got = 0, oe_idle = 100;
  logic prev_rd = 1'b1, prev_wr = 1'b1, prev_siwu = 1'b1;
  bit   rd_fell, rd_rose, wr_fell, wr_rose, siwu_fell;
  logic [7:0] dev_rxq[$], exp_rx[$], exp_tx[$], tx_src[$];
  int   order[$];

  always #5 clk = ~clk;

  ft2232_fifo_master dut (
    .clk(clk), .rst(rst), .DBUS_I(DBUS_I), .DBUS_O(DBUS_O), .DBUS_OE(DBUS_OE),
    .RXF(RXF), .TXE(TXE), .RD(RD), .WR(WR), .SIWU(SIWU),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .flush(flush)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // one clock: invariants, edge detection and (when enabled) the FT2232 device model
  task automatic tick();
    @(posedge clk);
    #1;
    rd_fell   = prev_rd && !RD;
    rd_rose   = !prev_rd && RD;
    wr_fell   = prev_wr && !WR;
    wr_rose   = !prev_wr && WR;
    siwu_fell = prev_siwu && !SIWU;
    prev_rd   = RD;
    prev_wr   = WR;
    prev_siwu = SIWU;
    chk("rd_oe_overlap", int'(!RD && DBUS_OE), 0);
    chk("one_strobe", int'((int'(!RD) + int'(!WR) + int'(!SIWU)) <= 1), 1);
    if (rd_fell) chk("oe_precharge", int'(oe_idle >= PRE), 1);
    oe_idle = rst ? 100 : (DBUS_OE ? 0 : oe_idle + 1);
    if (dev_en) begin
      if (siwu_fell) begin
        chk("siwu_requested", int'(pend), 1);
        pend = 1'b0;
      end
      if (flush) pend = 1'b1;
      if (rd_rose) begin
        chk("rd_with_data", int'(dev_rxq.size() > 0), 1);
        if (dev_rxq.size() > 0) exp_rx.push_back(dev_rxq.pop_front());
        rxf_cool = 1 + int'($urandom_range(2));
      end
      if (wr_rose) begin
        chk("wr_oe", int'(DBUS_OE), 1);
        chk("wr_expected", int'(exp_tx.size() > 0), 1);
        if (exp_tx.size() > 0) chk("wr_byte", int'(DBUS_O), int'(exp_tx.pop_front()));
        wr_got++;
        txe_cool = 1 + int'($urandom_range(3));
      end
      RXF    = (dev_rxq.size() > 0 && rxf_cool == 0) ? 1'b0 : 1'b1;
      TXE    = (txe_cool == 0 && $urandom_range(3) != 0) ? 1'b0 : 1'b1;
      DBUS_I = dev_rxq.size() > 0 ? dev_rxq[0] : 8'hEE;
      if (rxf_cool > 0) rxf_cool--;
      if (txe_cool > 0) txe_cool--;
    end
  endtask

  task automatic wait_hi(input int sel, input int lim, input string name);
    bit ok = 1'b0;
    for (int i = 0; i < lim && !ok; i++) begin
      tick();
      if ((sel == 0 ? tx_ready : rx_valid) == 1'b1) ok = 1'b1;
    end
    chk(name, int'(ok), 1);
  endtask

  task automatic measure_siwu(input int n, output int first, output int lows);
    first = -1;
    lows  = 0;
    for (int i = 1; i <= n; i++) begin
      tick();
      if (!SIWU) begin
        if (first < 0) first = i;
        lows++;
      end
    end
  endtask

  initial begin
    int first, lows;
    bit done;
    rst = 1'b1; RXF = 1'b1; TXE = 1'b1; DBUS_I = 8'h00; rx_ready = 1'b0;
    tx_valid = 1'b0; tx_data = 8'h00; flush = 1'b0;
    //         n rst rxf txe txv txd  rxr fl dbi     rd wr sw oe rxv txr rxd
    vt[0]  = '{1, 1,  1,  1,  0,  'h00, 0, 0, 'h00,  1, 1, 1, 0, 0,  0, 'h00};
    vt[1]  = '{2, 0,  0,  1,  0,  'h00, 1, 0, 'hA5,  1, 1, 1, 0, 0,  0, 'h00};
    vt[2]  = '{3, 0,  0,  1,  0,  'h00, 1, 0, 'hA5,  0, 1, 1, 0, 0,  0, 'h00};
    vt[3]  = '{1, 0,  0,  1,  0,  'h00, 1, 0, 'hA5,  1, 1, 1, 0, 1,  0, 'hA5};
    vt[4]  = '{6, 0,  1,  1,  0,  'h00, 1, 0, 'hA5,  1, 1, 1, 0, 0,  0, 'hA5};
    vt[5]  = '{2, 0,  0,  1,  0,  'h00, 0, 0, 'h5A,  1, 1, 1, 0, 0,  0, 'hA5};
    vt[6]  = '{3, 0,  0,  1,  0,  'h00, 0, 0, 'h5A,  0, 1, 1, 0, 0,  0, 'hA5};
    vt[7]  = '{1, 0,  0,  1,  0,  'h00, 0, 0, 'h5A,  1, 1, 1, 0, 1,  0, 'h5A};
    vt[8]  = '{6, 0,  0,  1,  0,  'h00, 0, 0, 'h5A,  1, 1, 1, 0, 1,  0, 'h5A};
    vt[9]  = '{2, 0,  1,  1,  0,  'h00, 0, 0, 'h5A,  1, 1, 1, 0, 1,  0, 'h5A};
    vt[10] = '{2, 0,  1,  1,  0,  'h00, 1, 0, 'h5A,  1, 1, 1, 0, 0,  0, 'h5A};
    for (int r = 0; r < 11; r++) begin
      rst = 1'(vt[r].rst); RXF = 1'(vt[r].rxf); TXE = 1'(vt[r].txe);
      tx_valid = 1'(vt[r].txv); tx_data = 8'(vt[r].txd); rx_ready = 1'(vt[r].rxr);
      flush = 1'(vt[r].fl); DBUS_I = 8'(vt[r].dbi);
      repeat (vt[r].n) begin
        tick();
        chk($sformatf("vec%0d_rd", r), int'(RD), vt[r].rd);
        chk($sformatf("vec%0d_wr", r), int'(WR), vt[r].wr);
        chk($sformatf("vec%0d_siwu", r), int'(SIWU), vt[r].siwu);
        chk($sformatf("vec%0d_oe", r), int'(DBUS_OE), vt[r].oe);
        chk($sformatf("vec%0d_rxv", r), int'(rx_valid), vt[r].rxv);
        chk($sformatf("vec%0d_txr", r), int'(tx_ready), vt[r].txr);
        chk($sformatf("vec%0d_rxd", r), int'(rx_data), vt[r].rxd);
      end
    end
    // single write of 0x3C
    TXE = 1'b0; tx_valid = 1'b1; tx_data = 8'h3C;
    wait_hi(0, 6, "wr_ready_wait");
    for (int i = 0; i < 9; i++) begin
      tick();
      if (i == 0) begin tx_valid = 1'b0; TXE = 1'b1; end
      chk($sformatf("wr%0d_oe", i), int'(DBUS_OE), int'(i < 5));
      chk($sformatf("wr%0d_wr", i), int'(WR), int'(!(i >= 1 && i <= 3)));
      chk($sformatf("wr%0d_txr", i), int'(tx_ready), 0);
      if (i < 5) chk($sformatf("wr%0d_dbus", i), int'(DBUS_O), 'h3C);
    end
    // flush while idle
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_idle_siwu_now", int'(SIWU), 1);
    measure_siwu(14, first, lows);
    chk("flush_idle_delay", first, 1);
    chk("flush_idle_width", lows, 3);
    // flush during WR_LOW, served after RECOVER
    TXE = 1'b0; tx_valid = 1'b1; tx_data = 8'hC3;
    wait_hi(0, 6, "wr2_ready_wait");
    tick();
    tx_valid = 1'b0; TXE = 1'b1;
    tick();
    chk("wr2_low", int'(WR), 0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("wr2_low_at_flush", int'(WR), 0);
    measure_siwu(14, first, lows);
    chk("flush_wr_delay", first, 8);
    chk("flush_wr_width", lows, 3);
    repeat (2) tick();
    // reset in the middle of a write with a byte held in the RX register
    RXF = 1'b0; DBUS_I = 8'h99; rx_ready = 1'b0;
    wait_hi(1, 10, "rst_pre_read_wait");
    RXF = 1'b1;
    chk("rst_pre_read_byte", int'(rx_data), 'h99);
    TXE = 1'b0; tx_valid = 1'b1; tx_data = 8'h77;
    wait_hi(0, 12, "rst_wr_ready_wait");
    tick();
    tick();
    chk("rst_wr_low", int'(WR), 0);
    rst = 1'b1;
    tick();
    chk("rst_wr", int'(WR), 1);
    chk("rst_oe", int'(DBUS_OE), 0);
    chk("rst_txr", int'(tx_ready), 0);
    chk("rst_rxv", int'(rx_valid), 0);
    chk("rst_rd", int'(RD), 1);
    rst = 1'b0; TXE = 1'b1; tx_valid = 1'b0; RXF = 1'b0; DBUS_I = 8'h42; rx_ready = 1'b1;
    repeat (2) tick();
    chk("post_rst_rd_idle", int'(RD), 1);
    tick();
    chk("post_rst_rd_low", int'(RD), 0);
    repeat (3) tick();
    RXF = 1'b1;
    chk("post_rst_rxv", int'(rx_valid), 1);
    chk("post_rst_rxd", int'(rx_data), 'h42);
    repeat (8) tick();
    // contention from a fresh reset: strict RD/WR alternation starting with RD
    rst = 1'b1; RXF = 1'b0; TXE = 1'b0; tx_valid = 1'b1; tx_data = 8'h22; DBUS_I = 8'h11;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 120; i++) begin
      tick();
      if (rd_fell) order.push_back(0);
      if (wr_fell) order.push_back(1);
    end
    chk("contention_count", int'(order.size() >= 8), 1);
    for (int i = 0; i < 8 && i < order.size(); i++)
      chk($sformatf("contention_order%0d", i), order[i], i % 2);
    RXF = 1'b1; TXE = 1'b1; tx_valid = 1'b0;
    repeat (14) tick();
    // randomized traffic against the device model and stream scoreboards
    for (int i = 0; i < 40; i++) begin
      dev_rxq.push_back(8'($urandom));
      tx_src.push_back(8'($urandom));
    end
    dev_en = 1'b1;
    done = 1'b0;
    for (int cyc = 0; cyc < 6000 && !done; cyc++) begin
      rx_ready = 1'($urandom_range(1));
      tx_valid = tx_src.size() > 0 && $urandom_range(2) != 0;
      tx_data  = tx_src.size() > 0 ? tx_src[0] : 8'h00;
      flush    = $urandom_range(39) == 0;
      #1;
      if (tx_valid && tx_ready) exp_tx.push_back(tx_src.pop_front());
      if (rx_valid && rx_ready) begin
        chk("rx_expected", int'(exp_rx.size() > 0), 1);
        if (exp_rx.size() > 0) chk("rx_byte", int'(rx_data), int'(exp_rx.pop_front()));
        rx_got++;
      end
      tick();
      done = rx_got == 40 && wr_got == 40;
    end
    flush = 1'b0; tx_valid = 1'b0; rx_ready = 1'b1;
    repeat (20) tick();
    chk("rand_rx_count", rx_got, 40);
    chk("rand_wr_count", wr_got, 40);
    chk("rand_rx_left", exp_rx.size(), 0);
    chk("rand_tx_left", exp_tx.size(), 0);
    chk("rand_flush_served", int'(pend), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
